uart_rx: RTL and testbench

UART receiver that deserialises an asynchronous 8N1 serial line into parallel bytes, using the 16×-oversampling `ticks` strobe from `baud_rate_gen`. It sits directly downstream of `baud_rate_gen` and feeds received bytes to the host-side command/loader logic. Each byte is announced with a one-cycle `rx_done_tick` pulse; a bad stop bit is flagged.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_if.sv | 22 ++
 rtl/uart_rx_sync_2ff.sv | 24 ++
 rtl/uart_rx.sv | 108 ++++++++++
 tb/tb_uart_rx.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state encoding.
package uart_pkg;

    localparam int NUM_TICKS       = 16;
    localparam int DBIT_DEFAULT    = 8;
    localparam int SB_TICK_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: oversampling strobe and serial line in, byte and status out.
interface uart_rx_if
    import uart_pkg::*;
#(
    parameter int DBIT = DBIT_DEFAULT
);
    logic            s_tick;
    logic            rx;
    logic [DBIT-1:0] dout;
    logic            rx_done_tick;
    logic            framing_error;

    modport master (
        output s_tick, rx,
        input  dout, rx_done_tick, framing_error
    );

    modport slave (
        input  s_tick, rx,
        output dout, rx_done_tick, framing_error
    );
endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer with a configurable reset level.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, mid-bit sampling on the 16x s_tick strobe.
// state | meaning: IDLE wait start edge | START find mid start bit | DATA shift bits | STOP sample stop
module uart_rx #(
    parameter int DBIT      = uart_pkg::DBIT_DEFAULT,
    parameter int SB_TICK   = uart_pkg::SB_TICK_DEFAULT,
    parameter int NUM_TICKS = uart_pkg::NUM_TICKS
) (
    input logic      clock_i,
    input logic      reset_i,
    uart_rx_if.slave bus
);
    import uart_pkg::*;

    localparam int SMAX = (NUM_TICKS > SB_TICK) ? NUM_TICKS : SB_TICK;
    localparam int SW   = $clog2(SMAX);
    localparam int NW   = $clog2(DBIT);

    localparam logic [SW-1:0] S_MID  = SW'(NUM_TICKS / 2 - 1);
    localparam logic [SW-1:0] S_BIT  = SW'(NUM_TICKS - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    rx_state_e       state_q;
    logic [SW-1:0]   s_q;
    logic [NW-1:0]   n_q;
    logic [DBIT-1:0] b_q;
    logic [DBIT-1:0] dout_q;
    logic            done_q;
    logic            ferr_q;
    logic            rx_s;

    sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .d_i     (bus.rx),
        .q_o     (rx_s)
    );

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_q <= ST_START;
                        s_q     <= '0;
                    end
                end
                ST_START: begin
                    if (bus.s_tick) begin
                        if (s_q == S_MID) begin
                            // Line went back high before mid start bit: glitch, not a frame.
                            if (!rx_s) begin
                                state_q <= ST_DATA;
                                s_q     <= '0;
                                n_q     <= '0;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            s_q <= s_q + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (bus.s_tick) begin
                        if (s_q == S_BIT) begin
                            s_q <= '0;
                            b_q <= {rx_s, b_q[DBIT-1:1]};
                            if (n_q == N_LAST) begin
                                state_q <= ST_STOP;
                            end else begin
                                n_q <= n_q + 1'b1;
                            end
                        end else begin
                            s_q <= s_q + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (bus.s_tick) begin
                        if (s_q == S_STOP) begin
                            dout_q  <= b_q;
                            ferr_q  <= ~rx_s;
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            s_q <= s_q + 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.dout          = dout_q;
    assign bus.rx_done_tick  = done_q;
    assign bus.framing_error = ferr_q;
endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: serial driver, 13-clock tick strobe, frame-level reference model.
module tb_uart_rx;

    localparam int TICK_DIV  = 13;
    localparam int BIT_CLK   = 16 * TICK_DIV;
    localparam int FRAME_CLK = 10 * BIT_CLK;
    localparam int BAD_STOP  = 10 * TICK_DIV;

    logic clk;
    logic rst;

    uart_rx_if #(.DBIT(8)) bus ();

    uart_rx dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];
    logic       prev_done = 1'b0;

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        bus.s_tick = 1'b0;
        forever begin
            repeat (TICK_DIV - 1) @(negedge clk);
            bus.s_tick = 1'b1;
            @(negedge clk);
            bus.s_tick = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (bus.rx_done_tick === 1'b1) got_q.push_back({bus.framing_error, bus.dout});
        if (prev_done) chk("pulse_width", {31'd0, bus.rx_done_tick}, 32'd0);
        prev_done = (bus.rx_done_tick === 1'b1);
    end

    // Reference: a frame yields its data byte, framing error = stop bit was low.
    task automatic send_frame(input logic [7:0] data, input bit stop_ok);
        exp_q.push_back({~stop_ok, data});
        bus.rx = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx = data[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        if (stop_ok) begin
            bus.rx = 1'b1;
            repeat (BIT_CLK) @(negedge clk);
        end else begin
            bus.rx = 1'b0;
            repeat (BAD_STOP) @(negedge clk);
            bus.rx = 1'b1;
            repeat (BIT_CLK) @(negedge clk);
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int waited = 0;
        logic [8:0] e;
        logic [8:0] g;
        while (got_q.size() < exp_q.size() && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            chk({tag, "_dout"}, {24'd0, g[7:0]}, {24'd0, e[7:0]});
            chk({tag, "_ferr"}, {31'd0, g[8]}, {31'd0, e[8]});
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic idle(input int clocks);
        bus.rx = 1'b1;
        repeat (clocks) @(negedge clk);
    endtask

    initial begin
        logic [7:0] rnd_byte;
        bit         rnd_stop;

        rst    = 1'b1;
        bus.rx = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_dout", {24'd0, bus.dout}, 32'd0);
        chk("reset_done", {31'd0, bus.rx_done_tick}, 32'd0);
        chk("reset_ferr", {31'd0, bus.framing_error}, 32'd0);
        rst = 1'b0;
        idle(300);

        send_frame(8'hA5, 1'b1);
        drain("a5", 2000);
        for (int i = 0; i < 10; i++) begin
            repeat (500) @(negedge clk);
            chk("a5_hold", {24'd0, bus.dout}, 32'hA5);
        end
        drain("a5_extra", 0);

        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        send_frame(8'h3C, 1'b1);
        drain("b2b", 2000);

        bus.rx = 1'b0;
        repeat (4 * TICK_DIV) @(negedge clk);
        idle(600);
        drain("false_start", 0);
        send_frame(8'h81, 1'b1);
        drain("after_glitch", 2000);

        send_frame(8'h3C, 1'b0);
        drain("bad_stop", 2000);
        chk("bad_stop_flag", {31'd0, bus.framing_error}, 32'd1);
        idle(200);
        send_frame(8'h11, 1'b1);
        drain("clean_after_bad", 2000);
        chk("ferr_cleared", {31'd0, bus.framing_error}, 32'd0);

        send_frame(8'h96, 1'b0);
        drain("bad_before_reset", 2000);
        idle(200);

        bus.rx = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.rx = 8'hC3 >> i;
            repeat (BIT_CLK) @(negedge clk);
        end
        bus.rx = 1'b0;
        repeat (100) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midframe_rst_dout", {24'd0, bus.dout}, 32'd0);
        chk("midframe_rst_ferr", {31'd0, bus.framing_error}, 32'd0);
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        bus.rx = 1'b1;
        idle(2500);
        drain("midframe_rst", 0);
        chk("post_rst_dout", {24'd0, bus.dout}, 32'd0);
        chk("post_rst_ferr", {31'd0, bus.framing_error}, 32'd0);
        send_frame(8'h5A, 1'b1);
        drain("after_rst", 2000);

        for (int i = 0; i < 3; i++) exp_q.push_back(9'h100);
        bus.rx = 1'b0;
        repeat (3 * FRAME_CLK) @(negedge clk);
        drain("break", 0);
        idle(2 * FRAME_CLK);
        got_q.delete();
        send_frame(8'h7E, 1'b1);
        drain("after_break", 2000);

        for (int i = 0; i < 8; i++) begin
            rnd_byte = 8'($urandom_range(0, 255));
            rnd_stop = ($urandom_range(0, 3) != 0);
            send_frame(rnd_byte, rnd_stop);
            idle($urandom_range(0, 300));
        end
        drain("random", 2000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
